// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_det_pkg;

    // Programmed length 0 selects the full pattern width.
    localparam int unsigned DEF_LEN     = 0;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Map an out-of-range active length (0 or wider than the pattern) to the full width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
        return ((len == 0) || (len > pat_w)) ? pat_w : len;
    endfunction

endpackage

// File: rtl/param_seq_detector_if.sv
// Config, serial data and status bundle of the sequence detector.
interface param_seq_detector_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cfg_diff;
    logic             x_valid;
    logic             x;
    logic             cnt_clr;
    logic             z;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_diff,
        output x_valid, x, cnt_clr,
        input  z, match_cnt
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_diff,
        input  x_valid, x, cnt_clr,
        output z, match_cnt
    );

endinterface

// File: rtl/seq_det_hist.sv
// Bit history shift register, fill counter and masked pattern compare.
module seq_det_hist #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             shift,
    input  logic             b,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             match_c
);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] fill_q;
    logic [LEN_W-1:0] fill_next;
    logic [PAT_W-1:0] mask;

    // Next-state history/fill and match on those next-state values.
    always_comb begin
        hist_next = hist_q;
        fill_next = fill_q;
        mask      = '0;
        if (shift) begin
            hist_next = {hist_q[PAT_W-2:0], b};
            fill_next = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
        end
        for (int i = 0; i < int'(PAT_W); i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        match_c = shift && (fill_next >= len) && ((hist_next & mask) == (pattern & mask));
    end

    // History state; a non-overlapping match restarts the fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (flush) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= hist_next;
            fill_q <= (match_c && !overlap) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial sequence detector with match pulse and saturating counter.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    param_seq_detector_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;
    logic             diff_q;
    logic             prev_x_q;
    logic             seeded_q;
    logic             z_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept_c;
    logic shift_c;
    logic b_c;
    logic match_c;

    // Load wins over data; in diff mode the first bit after reset/load only seeds prev_x.
    always_comb begin
        accept_c = bus.x_valid && !bus.cfg_load;
        shift_c  = accept_c && (!diff_q || seeded_q);
        b_c      = diff_q ? ~(bus.x ^ prev_x_q) : bus.x;
    end

    // Configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            len_q     <= LEN_W'(clamp_len(DEF_LEN, PAT_W));
            overlap_q <= DEF_OVERLAP;
            diff_q    <= 1'b0;
        end else if (bus.cfg_load) begin
            pattern_q <= bus.cfg_pattern;
            len_q     <= LEN_W'(clamp_len(32'(bus.cfg_len), PAT_W));
            overlap_q <= bus.cfg_overlap;
            diff_q    <= bus.cfg_diff;
        end
    end

    // Previous accepted bit for difference coding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_x_q <= 1'b0;
            seeded_q <= 1'b0;
        end else if (bus.cfg_load) begin
            prev_x_q <= 1'b0;
            seeded_q <= 1'b0;
        end else if (accept_c) begin
            prev_x_q <= bus.x;
            seeded_q <= 1'b1;
        end
    end

    seq_det_hist #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (bus.cfg_load),
        .shift   (shift_c),
        .b       (b_c),
        .pattern (pattern_q),
        .len     (len_q),
        .overlap (overlap_q),
        .match_c (match_c)
    );

    // Registered match pulse and saturating match counter (clear beats increment).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            z_q <= bus.cfg_load ? 1'b0 : match_c;
            if (bus.cfg_load || bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (match_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.z         = z_q;
    assign bus.match_cnt = cnt_q;

endmodule
